// File: rtl/reg_file_pkg.sv
// Shared types for the multi-port register file and its soft-clear engine.
package reg_file_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Sequential soft-clear engine: walks registers 1..NREGS-1 one per cycle and
// reports busy while walking plus a one-cycle done pulse afterwards.
module reg_file_clr_fsm
   import reg_file_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          clr_strobe,
   output logic [AW-1:0] clr_idx
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   clr_state_e    state_q;
   logic [AW-1:0] ptr_q;
   logic          busy_q;
   logic          done_q;

   // State, pointer and registered status outputs; register 0 is never visited.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (clr_req) begin
                  state_q <= CLEAR;
                  ptr_q   <= AW'(1);
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               if (ptr_q == LAST_IDX) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  ptr_q <= ptr_q + AW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy   = busy_q;
   assign clr_done   = done_q;
   assign clr_strobe = busy_q;
   assign clr_idx    = ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with same-cycle write bypass, a per-register
// pending scoreboard and a sequential soft-clear used on pipeline flush.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_pending,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_addr,
   input  logic                clr_req,
   output logic                clr_busy,
   output logic                clr_done
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] sb_q;
   logic [NREGS-1:0] sb_d;

   logic          clr_strobe;
   logic [AW-1:0] clr_idx;
   logic          sb_set_ok;

   reg_file_clr_fsm #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_clr_fsm (
      .clk        (clk),
      .reset      (reset),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy),
      .clr_done   (clr_done),
      .clr_strobe (clr_strobe),
      .clr_idx    (clr_idx)
   );

   // A scoreboard set is honoured only outside a clear and never for register 0.
   assign sb_set_ok = sb_set && !clr_strobe && (sb_addr != '0);

   // Next storage and scoreboard: ascending port loop makes the highest port win,
   // and the set is applied after the write-clears so a new producer wins.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         regs_d[r] = regs_q[r];
      end
      sb_d = sb_q;
      if (clr_strobe) begin
         regs_d[clr_idx] = '0;
         sb_d[clr_idx]   = 1'b0;
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
               regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
               sb_d[wr_addr[w*AW +: AW]]   = 1'b0;
            end
         end
         if (sb_set_ok) begin
            sb_d[sb_addr] = 1'b1;
         end
      end
      regs_d[0] = '0;
      sb_d[0]   = 1'b0;
   end

   // Storage and scoreboard flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
         sb_q <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
         sb_q <= sb_d;
      end
   end

   // Combinational read ports with optional forwarding of this cycle's winning write.
   always_comb begin
      logic [AW-1:0]   ra;
      logic            hit;
      logic [XLEN-1:0] fwd;
      rd_data    = '0;
      rd_pending = '0;
      for (int p = 0; p < NRD; p++) begin
         ra  = rd_addr[p*AW +: AW];
         hit = 1'b0;
         fwd = '0;
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
               hit = 1'b1;
               fwd = wr_data[w*XLEN +: XLEN];
            end
         end
         if (ra != '0) begin
            rd_data[p*XLEN +: XLEN] = regs_q[ra];
            rd_pending[p]           = sb_q[ra];
            if ((BYPASS != 0) && hit && !clr_strobe) begin
               rd_data[p*XLEN +: XLEN] = fwd;
               if (!(sb_set_ok && (sb_addr == ra))) begin
                  rd_pending[p] = 1'b0;
               end
            end
         end
      end
   end

endmodule
